// File: rtl/ahb_frame_dma.sv
// Single-channel frame DMA: strided 2-D reads and dense linear writes over an
// AHB-Lite master port, one word per rd_req/wr_req pulse.
module ahb_frame_dma #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 9
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_raddr,
  input  logic [ADDR_W-1:0] cfg_waddr,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_stride,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic              m_hwrite,
  output logic [DATA_W-1:0] m_hwdata,
  input  logic [DATA_W-1:0] m_hrdata,
  input  logic              m_hready
);
  localparam int CNT_W = 2 * DIM_W;
  localparam int SHIFT = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [2:0] {IDLE, ARB, RADDR, RDATA, WADDR, WDATA, FIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DIM_W-1:0]  width_q, stride_q, rcol, rrow;
  logic [CNT_W-1:0]  total_q, rcount, wcount;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_pend, wr_pend;
  logic [CNT_W-1:0]  rd_index;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              zero_dim, rd_left, wr_left, last_wr;

  assign zero_dim = (cfg_width == '0) || (cfg_height == '0);
  assign rd_left  = rcount < total_q;
  assign wr_left  = wcount < total_q;
  assign last_wr  = (wcount + CNT_W'(1)) == total_q;

  // row*stride+col never exceeds 2*DIM_W bits; wrap only happens in the address add
  assign rd_index = CNT_W'(rrow) * CNT_W'(stride_q) + CNT_W'(rcol);
  assign rd_addr  = raddr_q + (ADDR_W'(rd_index) << SHIFT);
  assign wr_addr  = waddr_q + (ADDR_W'(wcount) << SHIFT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_dim ? FIN : ARB;
      ARB: begin
        if (rd_pend && rd_left)      state_nxt = RADDR;
        else if (wr_pend && wr_left) state_nxt = WADDR;
      end
      RADDR:   if (m_hready) state_nxt = RDATA;
      RDATA:   if (m_hready) state_nxt = ARB;
      WADDR:   if (m_hready) state_nxt = WDATA;
      WDATA:   if (m_hready) state_nxt = last_wr ? FIN : ARB;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_htrans = 2'b00;
    m_hwrite = 1'b0;
    m_haddr  = '0;
    busy     = (state != IDLE) && (state != FIN);
    case (state)
      RADDR: begin
        m_htrans = 2'b10;
        m_haddr  = rd_addr;
      end
      WADDR: begin
        m_htrans = 2'b10;
        m_hwrite = 1'b1;
        m_haddr  = wr_addr;
      end
      default: ;
    endcase
  end

  assign m_hwdata = wdata_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raddr_q  <= '0;
      waddr_q  <= '0;
      width_q  <= '0;
      stride_q <= '0;
      total_q  <= '0;
      rcol     <= '0;
      rrow     <= '0;
      rcount   <= '0;
      wcount   <= '0;
      wdata_q  <= '0;
      rd_pend  <= 1'b0;
      wr_pend  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      done     <= (state == FIN);
      // requests beyond the frame's word count, or while one is held, are dropped
      if (state != IDLE) begin
        if (rd_req && !rd_pend && rd_left) rd_pend <= 1'b1;
        if (wr_req && !wr_pend && wr_left) begin
          wr_pend <= 1'b1;
          wdata_q <= wr_data;
        end
      end
      case (state)
        IDLE: if (start) begin
          raddr_q  <= cfg_raddr;
          waddr_q  <= cfg_waddr;
          width_q  <= cfg_width;
          stride_q <= (cfg_stride < cfg_width) ? cfg_width : cfg_stride;
          total_q  <= CNT_W'(cfg_width) * CNT_W'(cfg_height);
          rcol     <= '0;
          rrow     <= '0;
          rcount   <= '0;
          wcount   <= '0;
          rd_pend  <= 1'b0;
          wr_pend  <= 1'b0;
        end
        RDATA: if (m_hready) begin
          rd_data  <= m_hrdata;
          rd_valid <= 1'b1;
          rd_pend  <= 1'b0;
          rcount   <= rcount + CNT_W'(1);
          if (rcol == width_q - DIM_W'(1)) begin
            rcol <= '0;
            rrow <= rrow + DIM_W'(1);
          end else begin
            rcol <= rcol + DIM_W'(1);
          end
        end
        WDATA: if (m_hready) begin
          wr_done <= 1'b1;
          wr_pend <= 1'b0;
          wcount  <= wcount + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_frame_dma.sv
// Scoreboard bench for ahb_frame_dma: an AHB slave model with wait states,
// a frame-level address model, and a monitor that checks every completion.
`timescale 1ns/1ps
module tb_ahb_frame_dma;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DMW = 9;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           start = 1'b0;
  logic [AW-1:0]  cfg_raddr = '0, cfg_waddr = '0;
  logic [DMW-1:0] cfg_width = '0, cfg_height = '0, cfg_stride = '0;
  logic           rd_req = 1'b0, wr_req = 1'b0;
  logic [DW-1:0]  wr_data = '0;
  logic [DW-1:0]  rd_data;
  logic           rd_valid, wr_done, busy, done;
  logic [AW-1:0]  m_haddr;
  logic [1:0]     m_htrans;
  logic           m_hwrite;
  logic [DW-1:0]  m_hwdata;
  logic [DW-1:0]  m_hrdata = '0;
  logic           m_hready = 1'b1;

  ahb_frame_dma #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(DMW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .cfg_raddr(cfg_raddr), .cfg_waddr(cfg_waddr),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done),
    .busy(busy), .done(done),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hwdata(m_hwdata), .m_hrdata(m_hrdata), .m_hready(m_hready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an unexpected event or expired bound, required none (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Frame model: source word k sits at row k/w, column k%w of a pitched image
  int unsigned f_w, f_h, f_s, f_rk, f_wk, f_total;
  logic [31:0] f_raddr, f_waddr;

  function automatic logic [31:0] model_raddr(input int unsigned k);
    int unsigned pitch;
    pitch = (f_s < f_w) ? f_w : f_s;
    return f_raddr + ((k / f_w) * pitch + (k % f_w)) * 4;
  endfunction

  logic [31:0] exp_rd_addr[$], exp_rd_data[$], exp_wr_addr[$], exp_wr_data[$];
  bit          exp_wr_last[$];
  logic [31:0] bus_rd_addr[$], bus_wr_addr[$], bus_wr_data[$];
  int unsigned bus_rd_cyc[$];
  int          bus_rd_stall[$];
  int rd_issued = 0, wr_issued = 0, rd_seen = 0, wr_seen = 0;
  int done_expect = 0, done_lat = 0;
  int unsigned done_ref = 0;

  // AHB slave: hready for the current cycle is decided at its falling edge
  logic        in_data = 1'b0, cur_write = 1'b0;
  logic [31:0] cur_addr = '0;
  int          stall_left = 0, stall_plan = 0, ns_count = 0;
  int unsigned rd_ns_cyc = 0, wr_ns_cyc = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      in_data    = 1'b0;
      m_hready   = 1'b1;
      stall_left = 0;
    end else if (in_data) begin
      if (stall_left > 0) begin
        stall_left--;
        m_hready = 1'b0;
        m_hrdata = $urandom;
        check("stall_quiet", {m_htrans, rd_valid, wr_done, busy}, 5'b00001);
      end else begin
        m_hready = 1'b1;
        m_hrdata = cur_write ? $urandom : mem_word(cur_addr);
        if (cur_write) begin
          bus_wr_addr.push_back(cur_addr);
          bus_wr_data.push_back(m_hwdata);
        end
        in_data = 1'b0;
      end
    end else begin
      m_hready = 1'b1;
      m_hrdata = $urandom;
      if (m_htrans == 2'b10) begin
        ns_count++;
        cur_addr   = m_haddr;
        cur_write  = m_hwrite;
        in_data    = 1'b1;
        stall_left = stall_plan;
        if (m_hwrite) wr_ns_cyc = cyc;
        else begin
          rd_ns_cyc = cyc;
          bus_rd_addr.push_back(m_haddr);
          bus_rd_cyc.push_back(cyc);
          bus_rd_stall.push_back(stall_plan);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin : monitor
    logic [31:0] ea, ed, ba, bd;
    int unsigned bc;
    int          bs;
    bit          last;
    if (n_rst) begin
      if (rd_valid) begin
        rd_seen++;
        if (exp_rd_addr.size() == 0 || bus_rd_addr.size() == 0) fail("rd_unexpected");
        else begin
          ea = exp_rd_addr.pop_front();
          ed = exp_rd_data.pop_front();
          ba = bus_rd_addr.pop_front();
          bc = bus_rd_cyc.pop_front();
          bs = bus_rd_stall.pop_front();
          check("rd_haddr", ba, ea);
          check("rd_data", rd_data, ed);
          check("rd_latency", cyc - bc, 2 + bs);
        end
      end
      if (wr_done) begin
        wr_seen++;
        if (exp_wr_addr.size() == 0 || bus_wr_addr.size() == 0) fail("wr_unexpected");
        else begin
          ea   = exp_wr_addr.pop_front();
          ed   = exp_wr_data.pop_front();
          last = exp_wr_last.pop_front();
          ba   = bus_wr_addr.pop_front();
          bd   = bus_wr_data.pop_front();
          check("wr_haddr", ba, ea);
          check("wr_hwdata", bd, ed);
          if (last) begin
            done_expect++;
            done_ref = cyc;
            done_lat = 1;
          end
        end
      end
      if (done) begin
        if (done_expect == 0) fail("done_unexpected");
        else begin
          done_expect--;
          check("done_latency", cyc - done_ref, done_lat);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic start_frame(input int unsigned w, input int unsigned h, input int unsigned s,
                             input logic [31:0] ra, input logic [31:0] wa);
    f_w = w; f_h = h; f_s = s; f_raddr = ra; f_waddr = wa;
    f_rk = 0; f_wk = 0; f_total = w * h;
    cfg_width  = w[DMW-1:0];
    cfg_height = h[DMW-1:0];
    cfg_stride = s[DMW-1:0];
    cfg_raddr  = ra;
    cfg_waddr  = wa;
    start = 1'b1;
    if (f_total == 0) begin
      done_expect++;
      done_ref = cyc;
      done_lat = 2;
    end
    @(negedge clk);
    start = 1'b0;
    // config must have been latched; scramble it
    cfg_raddr = $urandom; cfg_waddr = $urandom;
    cfg_width = DMW'($urandom); cfg_height = DMW'($urandom); cfg_stride = DMW'($urandom);
    if (f_total != 0) check("busy_after_start", busy, 1);
  endtask

  task automatic issue(input bit r, input bit w);
    logic [31:0] d;
    d = $urandom;
    if (r) begin
      exp_rd_addr.push_back(model_raddr(f_rk));
      exp_rd_data.push_back(mem_word(model_raddr(f_rk)));
      f_rk++;
      rd_issued++;
    end
    if (w) begin
      exp_wr_addr.push_back(f_waddr + f_wk * 4);
      exp_wr_data.push_back(d);
      exp_wr_last.push_back(f_wk + 1 == f_total);
      f_wk++;
      wr_issued++;
    end
    rd_req = r; wr_req = w; wr_data = d;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; wr_data = $urandom;
  endtask

  task automatic pulse_raw(input bit r, input bit w);
    rd_req = r; wr_req = w; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((rd_seen != rd_issued || wr_seen != wr_issued) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("timeout_transfers");
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_expect != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("timeout_done");
  endtask

  task automatic run_frame(input int unsigned w, input int unsigned h, input int unsigned s,
                           input logic [31:0] ra, input logic [31:0] wa,
                           input int unsigned nreads, input int max_stall);
    bit r, wv;
    start_frame(w, h, s, ra, wa);
    while (f_wk < f_total) begin
      r  = (f_rk < nreads) && ($urandom_range(0, 1) == 1);
      wv = ($urandom_range(0, 2) != 0) || !r;
      stall_plan = $urandom_range(0, max_stall);
      issue(r, wv);
      wait_quiet();
    end
    wait_done();
    @(negedge clk);
    check("busy_idle_after_frame", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {rd_data, m_hwdata}, '0);
    check({tag, "_ctl"}, {m_haddr, m_htrans, m_hwrite, rd_valid, wr_done, busy, done}, '0);
  endtask

  initial begin : watchdog
    #600000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : stim
    int ns0, ws0;
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    n_rst = 1'b1;
    @(negedge clk);

    // 2x2 frame, pitch 4 words, source at 0x1000, no wait states
    run_frame(2, 2, 4, 32'h0000_1000, 32'h0000_4000, 4, 0);

    // 1x4 frame: tie priority, wait states, dropped duplicates, frame end
    stall_plan = 0;
    start_frame(1, 4, 0, 32'h0000_2000, 32'h0000_8000);
    issue(1, 1);
    wait_quiet();
    check("read_before_write", wr_ns_cyc > rd_ns_cyc, 1);
    stall_plan = 3;
    issue(1, 0);
    wait_quiet();
    stall_plan = 0;
    issue(0, 1);
    pulse_raw(0, 1);
    wait_quiet();
    issue(1, 1);
    wait_quiet();
    issue(1, 0);
    wait_quiet();
    ns0 = ns_count;
    pulse_raw(1, 0);
    repeat (8) @(negedge clk);
    check("rd_after_last_dropped", ns_count, ns0);
    issue(0, 1);
    wait_quiet();
    wait_done();
    @(negedge clk);
    check("busy_after_1x4", busy, 0);
    ns0 = ns_count;
    ws0 = wr_seen;
    pulse_raw(0, 1);
    repeat (8) @(negedge clk);
    check("wr_after_done_bus", ns_count, ns0);
    check("wr_after_done_cnt", wr_seen, ws0);

    // zero-width frame finishes without touching the bus
    ns0 = ns_count;
    start_frame(0, 3, 2, 32'h0000_3000, 32'h0000_5000);
    wait_done();
    check("zero_dim_no_bus", ns_count, ns0);
    check("zero_dim_busy", busy, 0);

    // source address wrapping through the top of the address space
    run_frame(3, 2, 5, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 6, 1);

    for (int i = 0; i < 6; i++) begin
      int unsigned w, h;
      w = $urandom_range(1, 4);
      h = $urandom_range(1, 4);
      run_frame(w, h, $urandom_range(0, 6), $urandom & 32'hFFFF_FFFC,
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, w * h), 2);
    end

    // reset in the middle of a write data phase
    start_frame(2, 2, 2, 32'h0000_6000, 32'h0000_A000);
    stall_plan = 6;
    ns0 = ns_count;
    issue(0, 1);
    n = 0;
    while (ns_count == ns0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("timeout_reset_write");
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("reset_async");
    exp_rd_addr.delete(); exp_rd_data.delete();
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_wr_last.delete();
    bus_rd_addr.delete(); bus_rd_cyc.delete(); bus_rd_stall.delete();
    bus_wr_addr.delete(); bus_wr_data.delete();
    rd_issued = rd_seen;
    wr_issued = wr_seen;
    done_expect = 0;
    stall_plan = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    ns0 = ns_count;
    repeat (4) @(negedge clk);
    check("idle_after_reset_busy", busy, 0);
    check("idle_after_reset_bus", ns_count, ns0);
    run_frame(2, 1, 0, 32'h0000_7000, 32'h0000_C000, 2, 0);

    check("leftover_rd", exp_rd_addr.size(), 0);
    check("leftover_wr", exp_wr_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
